ahb_sram_slave: RTL and testbench

AHB-Lite responder that bridges the core AHB bus to a single-port synchronous SRAM bank with one-cycle read latency. It serves single and INCR/SEQ burst transfers from bus masters such as the cache bus unit, including 256-beat line fills and write-backs. It generates byte enables from hsize and haddr, inserts configurable wait states, and returns a two-cycle ERROR response for illegal accesses.

---
 rtl/ahb_sram_slave.sv | 182 ++++++++++++++++++
 tb/tb_ahb_sram_slave.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder in front of a single-port synchronous SRAM with one-cycle read latency.
// It decodes the byte enables, inserts optional wait states and returns a two-cycle ERROR response.
module ahb_sram_slave #(
    parameter int unsigned MEM_AW    = 11,
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter int unsigned WAIT_CYC  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hsel,
    input  logic [63:0]       haddr,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    input  logic [1:0]        htrans,
    input  logic [63:0]       hwdata,
    input  logic              hready_in,
    output logic              hreadyout,
    output logic              hresp,
    output logic [63:0]       hrdata,
    output logic              sram_cs,
    output logic              sram_we,
    output logic [MEM_AW-1:0] sram_addr,
    output logic [7:0]        sram_be,
    output logic [63:0]       sram_wdata,
    input  logic [63:0]       sram_rdata
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_ISS,
        ST_RD_WT,
        ST_RD_RSP,
        ST_WR_WT,
        ST_WR_RSP,
        ST_ERR1,
        ST_ERR2
    } state_e;

    localparam logic [2:0] WAIT_LD  = 3'(WAIT_CYC);
    localparam bit         HAS_WAIT = (WAIT_CYC != 0);

    function automatic logic [7:0] calc_be(input logic [2:0] size, input logic [2:0] lane);
        case (size)
            3'd0:    calc_be = 8'h01 << lane;
            3'd1:    calc_be = 8'h03 << lane;
            3'd2:    calc_be = 8'h0F << lane;
            3'd3:    calc_be = 8'hFF;
            default: calc_be = 8'h00;
        endcase
    endfunction

    // Oversized transfers are flagged separately, so they read as aligned here.
    function automatic logic is_misaligned(input logic [2:0] size, input logic [2:0] lane);
        case (size)
            3'd0:    is_misaligned = 1'b0;
            3'd1:    is_misaligned = lane[0];
            3'd2:    is_misaligned = |lane[1:0];
            3'd3:    is_misaligned = |lane;
            default: is_misaligned = 1'b0;
        endcase
    endfunction

    state_e            state_q, state_d;
    logic [MEM_AW-1:0] addr_q, addr_d;
    logic [7:0]        be_q, be_d;
    logic [2:0]        cnt_q, cnt_d;

    logic [63:0] off_s;
    logic        illegal_s;
    logic        accept_s;
    state_e      disp_st_s;
    logic        unused_s;

    assign unused_s = ^{hburst, htrans[0]};
    assign off_s    = haddr - BASE_ADDR;
    assign accept_s = hsel & hready_in & htrans[1];

    // Classify the address phase on the bus and choose the state it dispatches to.
    always_comb begin
        illegal_s = (haddr < BASE_ADDR) ||
                    ((off_s >> (MEM_AW + 3)) != 64'd0) ||
                    (hsize > 3'd3) ||
                    is_misaligned(hsize, haddr[2:0]);
        if (illegal_s) begin
            disp_st_s = ST_ERR1;
        end else if (!hwrite) begin
            disp_st_s = ST_RD_ISS;
        end else if (HAS_WAIT) begin
            disp_st_s = ST_WR_WT;
        end else begin
            disp_st_s = ST_WR_RSP;
        end
    end

    // Bus and SRAM outputs, decoded from the current state only.
    always_comb begin
        hreadyout  = 1'b0;
        hresp      = 1'b0;
        hrdata     = 64'd0;
        sram_cs    = 1'b0;
        sram_we    = 1'b0;
        sram_be    = 8'd0;
        sram_wdata = 64'd0;
        sram_addr  = addr_q;
        case (state_q)
            ST_IDLE:   hreadyout = 1'b1;
            ST_RD_ISS: sram_cs = 1'b1;
            ST_RD_WT:  hreadyout = 1'b0;
            ST_RD_RSP: begin
                hreadyout = 1'b1;
                hrdata    = sram_rdata;
            end
            ST_WR_WT:  hreadyout = 1'b0;
            ST_WR_RSP: begin
                hreadyout  = 1'b1;
                sram_cs    = 1'b1;
                sram_we    = 1'b1;
                sram_be    = be_q;
                sram_wdata = hwdata;
            end
            ST_ERR1:   hresp = 1'b1;
            ST_ERR2: begin
                hreadyout = 1'b1;
                hresp     = 1'b1;
            end
            default:   hreadyout = 1'b1;
        endcase
    end

    // Next-state logic; every hreadyout-high state may accept a pipelined address phase.
    always_comb begin
        state_d = state_q;
        cnt_d   = WAIT_LD;
        case (state_q)
            ST_IDLE:   state_d = accept_s ? disp_st_s : ST_IDLE;
            ST_RD_ISS: state_d = HAS_WAIT ? ST_RD_WT : ST_RD_RSP;
            ST_RD_WT: begin
                if (cnt_q <= 3'd1) begin
                    state_d = ST_RD_RSP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_RD_RSP: state_d = accept_s ? disp_st_s : ST_IDLE;
            ST_WR_WT: begin
                if (cnt_q <= 3'd1) begin
                    state_d = ST_WR_RSP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_WR_RSP: state_d = accept_s ? disp_st_s : ST_IDLE;
            ST_ERR1:   state_d = ST_ERR2;
            ST_ERR2:   state_d = accept_s ? disp_st_s : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        if (hreadyout && accept_s) begin
            addr_d = off_s[MEM_AW+2:3];
            be_d   = calc_be(hsize, haddr[2:0]);
        end else begin
            addr_d = addr_q;
            be_d   = be_q;
        end
    end

    // State and captured address-phase registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            be_q    <= 8'd0;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: one responder with no wait states and one with two, each backed by an SRAM model.
module tb_ahb_sram_slave;

    localparam int unsigned AW    = 11;
    localparam int unsigned DEPTH = 2048;
    localparam logic [63:0] BASE  = 64'h0000_0000_4000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel, use2;
    logic        hsel0, hsel2;
    logic [63:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize, hburst;
    logic [1:0]  htrans;
    logic [63:0] hwdata;

    logic          rdy0, resp0, cs0, we0, rdy2, resp2, cs2, we2;
    logic [63:0]   hrdata0, wdata0, rdata0, hrdata2, wdata2, rdata2;
    logic [AW-1:0] addr0, addr2;
    logic [7:0]    be0, be2;

    logic [63:0] mem0 [DEPTH];
    logic [63:0] mem2 [DEPTH];
    logic        loaded = 1'b0;

    logic          m_rdy, m_resp, m_cs, m_we;
    logic [63:0]   m_hrdata, m_wdata;
    logic [AW-1:0] m_addr;
    logic [7:0]    m_be;

    int          vectors, miscompares;
    int          low_cnt, resp_cnt, cs_cnt, stb_i, bl, abort_cs;
    logic        done, st_we;
    logic [63:0] st_addr, st_be, st_wdata, r_data;

    always #5 clk = ~clk;

    assign hsel0    = sel & ~use2;
    assign hsel2    = sel & use2;
    assign m_rdy    = use2 ? rdy2 : rdy0;
    assign m_resp   = use2 ? resp2 : resp0;
    assign m_cs     = use2 ? cs2 : cs0;
    assign m_we     = use2 ? we2 : we0;
    assign m_hrdata = use2 ? hrdata2 : hrdata0;
    assign m_wdata  = use2 ? wdata2 : wdata0;
    assign m_addr   = use2 ? addr2 : addr0;
    assign m_be     = use2 ? be2 : be0;

    ahb_sram_slave #(.MEM_AW(AW), .BASE_ADDR(BASE), .WAIT_CYC(0)) u_dut0 (
        .clk(clk), .rst(rst), .hsel(hsel0), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .htrans(htrans), .hwdata(hwdata), .hready_in(rdy0), .hreadyout(rdy0),
        .hresp(resp0), .hrdata(hrdata0), .sram_cs(cs0), .sram_we(we0), .sram_addr(addr0),
        .sram_be(be0), .sram_wdata(wdata0), .sram_rdata(rdata0)
    );

    ahb_sram_slave #(.MEM_AW(AW), .BASE_ADDR(BASE), .WAIT_CYC(2)) u_dut2 (
        .clk(clk), .rst(rst), .hsel(hsel2), .haddr(haddr), .hwrite(hwrite), .hsize(hsize),
        .hburst(hburst), .htrans(htrans), .hwdata(hwdata), .hready_in(rdy2), .hreadyout(rdy2),
        .hresp(resp2), .hrdata(hrdata2), .sram_cs(cs2), .sram_we(we2), .sram_addr(addr2),
        .sram_be(be2), .sram_wdata(wdata2), .sram_rdata(rdata2)
    );

    function automatic logic [63:0] pat(input int k);
        pat = {32'hC0DE_0000 + 32'(k), 32'h1234_5678 ^ 32'(k)};
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] nw,
                                          input logic [7:0] be);
        merge = old;
        for (int b = 0; b < 8; b++) begin
            if (be[b]) merge[b*8 +: 8] = nw[b*8 +: 8];
        end
    endfunction

    // Word 2 of bank 0 has been rewritten by the single-transfer steps before the burst.
    function automatic logic [63:0] bexp(input int j);
        bexp = (j == 2) ? 64'h1122_3344_A523_4567 : pat(j);
    endfunction

    // SRAM models: preloaded once, byte-masked writes, read data held until the next read.
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem0[i] <= pat(i);
                mem2[i] <= pat(i);
            end
            loaded <= 1'b1;
        end else begin
            if (cs0 && we0)  mem0[addr0] <= merge(mem0[addr0], wdata0, be0);
            if (cs0 && !we0) rdata0 <= mem0[addr0];
            if (cs2 && we2)  mem2[addr2] <= merge(mem2[addr2], wdata2, be2);
            if (cs2 && !we2) rdata2 <= mem2[addr2];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One single transfer: address phase then a bounded data phase, recording what was seen.
    task automatic xfer(input logic wr, input logic [63:0] addr, input logic [2:0] size,
                        input logic [63:0] wdata);
        sel = 1'b1; haddr = addr; hwrite = wr; hsize = size; htrans = 2'b10; hburst = 3'b000;
        @(negedge clk);
        check("addr_phase_ready", 64'(m_rdy), 64'd1);
        @(posedge clk); #1;
        sel = 1'b0; htrans = 2'b00; hwdata = wdata;
        low_cnt = 0; resp_cnt = 0; cs_cnt = 0; stb_i = -1; done = 1'b0;
        st_we = 1'b0; st_addr = 64'd0; st_be = 64'd0; st_wdata = 64'd0; r_data = 64'd0;
        for (int i = 0; i < 16 && !done; i++) begin
            @(negedge clk);
            if (m_resp) resp_cnt++;
            if (m_cs) begin
                cs_cnt++; stb_i = i; st_we = m_we; st_addr = 64'(m_addr);
                st_be = 64'(m_be); st_wdata = m_wdata;
            end
            if (m_rdy) begin
                done = 1'b1; r_data = m_hrdata;
            end else begin
                low_cnt++;
            end
            @(posedge clk); #1;
        end
        check("xfer_done", 64'(done), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1; sel = 1'b0; use2 = 1'b0; haddr = 64'd0; hwrite = 1'b0;
        hsize = 3'd0; hburst = 3'd0; htrans = 2'b00; hwdata = 64'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_hready0", 64'(rdy0), 64'd1);
        check("rst_hresp0", 64'(resp0), 64'd0);
        check("rst_hrdata0", hrdata0, 64'd0);
        check("rst_cs0", 64'(cs0), 64'd0);
        check("rst_we0", 64'(we0), 64'd0);
        check("rst_be0", 64'(be0), 64'd0);
        check("rst_addr0", 64'(addr0), 64'd0);
        check("rst_hready2", 64'(rdy2), 64'd1);
        check("rst_cs2", 64'(cs2), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // No-wait responder: dword write/read, byte and word merges, last legal word.
        xfer(1'b1, BASE + 64'h10, 3'd3, 64'hDEAD_BEEF_0123_4567);
        check("wr_dw_low", 64'(low_cnt), 64'd0);
        check("wr_dw_cs", 64'(cs_cnt), 64'd1);
        check("wr_dw_we", 64'(st_we), 64'd1);
        check("wr_dw_addr", st_addr, 64'd2);
        check("wr_dw_be", st_be, 64'hFF);
        check("wr_dw_wdata", st_wdata, 64'hDEAD_BEEF_0123_4567);
        check("wr_dw_hrdata", r_data, 64'd0);
        check("wr_dw_resp", 64'(resp_cnt), 64'd0);
        xfer(1'b0, BASE + 64'h10, 3'd3, 64'd0);
        check("rd_dw_low", 64'(low_cnt), 64'd1);
        check("rd_dw_we", 64'(st_we), 64'd0);
        check("rd_dw_addr", st_addr, 64'd2);
        check("rd_dw_data", r_data, 64'hDEAD_BEEF_0123_4567);

        xfer(1'b1, BASE + 64'h13, 3'd0, 64'h0000_0000_A500_0000);
        check("wr_b_be", st_be, 64'h08);
        check("wr_b_wdata", st_wdata, 64'h0000_0000_A500_0000);
        xfer(1'b0, BASE + 64'h10, 3'd3, 64'd0);
        check("rd_b_data", r_data, 64'hDEAD_BEEF_A523_4567);

        xfer(1'b1, BASE + 64'h14, 3'd2, 64'h1122_3344_0000_0000);
        check("wr_w_be", st_be, 64'hF0);
        xfer(1'b0, BASE + 64'h10, 3'd3, 64'd0);
        check("rd_w_data", r_data, 64'h1122_3344_A523_4567);

        xfer(1'b1, BASE + 64'h3FF8, 3'd3, 64'hCAFE_F00D_0BAD_BEEF);
        check("wr_last_addr", st_addr, 64'h7FF);
        check("wr_last_resp", 64'(resp_cnt), 64'd0);
        check("wr_last_cs", 64'(cs_cnt), 64'd1);

        // Illegal accesses: window end, misaligned word, below base, oversize.
        xfer(1'b0, BASE + 64'h4000, 3'd3, 64'd0);
        check("err_end_resp", 64'(resp_cnt), 64'd2);
        check("err_end_low", 64'(low_cnt), 64'd1);
        check("err_end_cs", 64'(cs_cnt), 64'd0);
        check("err_end_hrdata", r_data, 64'd0);
        xfer(1'b0, BASE + 64'h2, 3'd2, 64'd0);
        check("err_mis_resp", 64'(resp_cnt), 64'd2);
        check("err_mis_low", 64'(low_cnt), 64'd1);
        check("err_mis_cs", 64'(cs_cnt), 64'd0);
        xfer(1'b1, BASE - 64'h8, 3'd3, 64'h1);
        check("err_low_resp", 64'(resp_cnt), 64'd2);
        check("err_low_cs", 64'(cs_cnt), 64'd0);
        xfer(1'b0, BASE, 3'd4, 64'd0);
        check("err_size_resp", 64'(resp_cnt), 64'd2);

        // 256-beat INCR read: one low cycle per beat, data straight from the SRAM.
        use2 = 1'b0; sel = 1'b1; hwrite = 1'b0; hsize = 3'd3; hburst = 3'b001; resp_cnt = 0;
        for (int k = 0; k <= 256; k++) begin
            if (k < 256) begin
                haddr = BASE + 64'(k) * 64'd8; htrans = (k == 0) ? 2'b10 : 2'b11;
            end else begin
                sel = 1'b0; htrans = 2'b00;
            end
            bl = 0; done = 1'b0;
            for (int w = 0; w < 8 && !done; w++) begin
                @(negedge clk);
                if (m_resp) resp_cnt++;
                if (m_rdy) begin
                    done = 1'b1;
                end else begin
                    bl++; @(posedge clk); #1;
                end
            end
            if (k > 0) begin
                check("burst_done", 64'(done), 64'd1);
                check("burst_wait", 64'(bl), 64'd1);
                check("burst_data", m_hrdata, bexp(k - 1));
            end else begin
                check("burst_start", 64'(bl), 64'd0);
            end
            @(posedge clk); #1;
        end
        check("burst_hresp", 64'(resp_cnt), 64'd0);

        // Two-wait responder.
        use2 = 1'b1;
        xfer(1'b0, BASE + 64'h10, 3'd3, 64'd0);
        check("w2_rd_low", 64'(low_cnt), 64'd3);
        check("w2_rd_data", r_data, pat(2));
        xfer(1'b1, BASE + 64'h18, 3'd3, 64'h0F0E_0D0C_0B0A_0908);
        check("w2_wr_low", 64'(low_cnt), 64'd2);
        check("w2_wr_stb", 64'(stb_i), 64'd2);
        check("w2_wr_cs", 64'(cs_cnt), 64'd1);
        check("w2_wr_addr", st_addr, 64'd3);
        xfer(1'b0, BASE + 64'h18, 3'd3, 64'd0);
        check("w2_rdb_data", r_data, 64'h0F0E_0D0C_0B0A_0908);

        // Reset while a burst beat is in RD_WT.
        sel = 1'b1; hwrite = 1'b0; hsize = 3'd3; hburst = 3'b001; htrans = 2'b10; haddr = BASE + 64'h20;
        @(negedge clk);
        @(posedge clk); #1;
        htrans = 2'b11; haddr = BASE + 64'h28;
        @(negedge clk);
        check("rst_rdiss_cs", 64'(m_cs), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rst_rdwt_rdy", 64'(m_rdy), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0; sel = 1'b0; htrans = 2'b00;
        @(negedge clk);
        check("rst_after_rdy", 64'(m_rdy), 64'd1);
        check("rst_after_resp", 64'(m_resp), 64'd0);
        check("rst_after_cs", 64'(m_cs), 64'd0);
        check("rst_after_hrdata", m_hrdata, 64'd0);
        @(posedge clk); #1;

        // Reset while a write waits: the SRAM must never see the strobe.
        sel = 1'b1; hwrite = 1'b1; hsize = 3'd3; hburst = 3'b000; htrans = 2'b10; haddr = BASE + 64'h30;
        @(negedge clk);
        @(posedge clk); #1;
        sel = 1'b0; htrans = 2'b00; hwdata = 64'hFFFF_FFFF_FFFF_FFFF; rst = 1'b1; abort_cs = 0;
        @(negedge clk);
        if (m_cs) abort_cs++;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (m_cs) abort_cs++;
            @(posedge clk); #1;
        end
        check("abort_no_cs", 64'(abort_cs), 64'd0);
        xfer(1'b0, BASE + 64'h30, 3'd3, 64'd0);
        check("abort_mem", r_data, pat(6));
        xfer(1'b1, BASE + 64'h38, 3'd3, 64'h7766_5544_3322_1100);
        check("post_rst_wr_low", 64'(low_cnt), 64'd2);
        check("post_rst_wr_stb", 64'(stb_i), 64'd2);
        xfer(1'b0, BASE + 64'h38, 3'd3, 64'd0);
        check("post_rst_rd", r_data, 64'h7766_5544_3322_1100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
